// File: rtl/front_panel_jam_seq.sv
// Front-panel EXAMINE / EXAMINE NEXT / DEPOSIT / DEPOSIT NEXT sequencer.
// Jams JMP <addr> or NOP bytes into the CPU instruction stream on successive
// read strobes, issues panel memory writes, and tracks the panel address.
module front_panel_jam_seq #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 16,
  parameter logic [DATA_W-1:0] JMP_OPCODE = DATA_W'(8'hC3),
  parameter logic [DATA_W-1:0] NOP_OPCODE = DATA_W'(8'h00),
  parameter int                NOP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] addr_sw,
  input  logic [DATA_W-1:0] data_sw,
  input  logic              rd,
  output logic              cmd_ready,
  output logic              busy,
  output logic              jam_en,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] panel_addr,
  output logic              done
);

  localparam int NBYTES = ADDR_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = (NOP_CYCLES > 1) ? $clog2(NOP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NOP_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_JAM_OP   = 3'd1;
  localparam logic [2:0] S_JAM_ADDR = 3'd2;
  localparam logic [2:0] S_JAM_NOP  = 3'd3;
  localparam logic [2:0] S_REL      = 3'd4;
  localparam logic [2:0] S_DEP      = 3'd5;
  localparam logic [2:0] S_FIN      = 3'd6;

  localparam logic [1:0] OP_EXAM     = 2'b00;
  localparam logic [1:0] OP_EXAM_NXT = 2'b01;
  localparam logic [1:0] OP_DEP      = 2'b10;
  localparam logic [1:0] OP_DEP_NXT  = 2'b11;

  logic [2:0]        r_state;
  logic              r_rd_q;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_op;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_nop_cnt;
  logic              r_jam_en;
  logic [DATA_W-1:0] r_data_out;
  logic [ADDR_W-1:0] r_panel;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_rd_rise;

  // Byte idx of the address, LSB first, zero-extended onto the data bus.
  function automatic logic [DATA_W-1:0] addr_byte(input logic [ADDR_W-1:0] a,
                                                  input logic [IDX_W-1:0]  idx);
    return DATA_W'(8'(a >> (8 * idx)));
  endfunction

  assign w_rd_rise = rd & ~r_rd_q;

  // Sequencer: command acceptance, byte jamming, release and deposit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rd_q     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_op       <= '0;
      r_idx      <= '0;
      r_nop_cnt  <= '0;
      r_jam_en   <= 1'b0;
      r_data_out <= '0;
      r_panel    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      // rd_q tracks rd unconditionally so a level already high at acceptance
      // never looks like a fresh read.
      r_rd_q <= rd;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr    <= addr_sw;
            r_data    <= data_sw;
            r_op      <= cmd_op;
            r_idx     <= '0;
            r_nop_cnt <= '0;
            case (cmd_op)
              OP_EXAM: begin
                r_state    <= S_JAM_OP;
                r_jam_en   <= 1'b1;
                r_data_out <= JMP_OPCODE;
              end
              OP_DEP: begin
                r_state <= S_DEP;
                r_waddr <= r_panel;
                r_wdata <= data_sw;
              end
              default: begin
                r_state    <= S_JAM_NOP;
                r_jam_en   <= 1'b1;
                r_data_out <= NOP_OPCODE;
              end
            endcase
          end
        end
        S_JAM_OP: begin
          if (w_rd_rise) begin
            r_state    <= S_JAM_ADDR;
            r_idx      <= '0;
            r_data_out <= addr_byte(r_addr, '0);
          end
        end
        S_JAM_ADDR: begin
          if (w_rd_rise) begin
            if (r_idx == IDX_LAST) begin
              r_state <= S_REL;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_data_out <= addr_byte(r_addr, r_idx + 1'b1);
            end
          end
        end
        S_JAM_NOP: begin
          if (w_rd_rise) begin
            if (r_nop_cnt == CNT_LAST) begin
              r_state <= S_REL;
            end else begin
              r_nop_cnt <= r_nop_cnt + 1'b1;
            end
          end
        end
        S_REL: begin
          // Keep driving the last byte until the CPU finishes the read.
          if (!rd) begin
            r_jam_en   <= 1'b0;
            r_data_out <= '0;
            case (r_op)
              OP_EXAM: begin
                r_panel <= r_addr;
                r_state <= S_FIN;
              end
              OP_DEP_NXT: begin
                r_panel <= r_panel + 1'b1;
                r_waddr <= r_panel + 1'b1;
                r_wdata <= r_data;
                r_state <= S_DEP;
              end
              default: begin
                r_panel <= r_panel + 1'b1;
                r_state <= S_FIN;
              end
            endcase
          end
        end
        S_DEP:   r_state <= S_FIN;
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign mem_wr     = (r_state == S_DEP);
  assign done       = (r_state == S_FIN);
  assign jam_en     = r_jam_en;
  assign data_out   = r_data_out;
  assign mem_waddr  = r_waddr;
  assign mem_wdata  = r_wdata;
  assign panel_addr = r_panel;

endmodule

// File: tb/tb_front_panel_jam_seq.sv
// Bench for front_panel_jam_seq: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue-based model.
module tb_front_panel_jam_seq;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] addr_sw;
  logic [7:0]  data_sw;
  logic        rd;
  logic        cmd_ready;
  logic        busy;
  logic        jam_en;
  logic [7:0]  data_out;
  logic        mem_wr;
  logic [15:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic [15:0] panel_addr;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  front_panel_jam_seq dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .addr_sw    (addr_sw),
    .data_sw    (data_sw),
    .rd         (rd),
    .cmd_ready  (cmd_ready),
    .busy       (busy),
    .jam_en     (jam_en),
    .data_out   (data_out),
    .mem_wr     (mem_wr),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .panel_addr (panel_addr),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a command becomes a queue of bytes the CPU must read,
  // followed by a release, an optional write and a completion pulse.
  typedef enum {P_IDLE, P_JAM, P_REL, P_DEP, P_FIN} phase_t;
  phase_t      ph = P_IDLE;
  logic [7:0]  mq[$];
  logic [1:0]  m_op = '0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [15:0] m_panel = '0;
  logic [15:0] m_wa = '0;
  logic [7:0]  m_wd = '0;
  logic        m_rdq = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_rise;

  always @(posedge clk) begin
    if (reset) begin
      ph = P_IDLE;
      mq.delete();
      m_panel = '0;
      m_wa = '0;
      m_wd = '0;
      m_rdq = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_rise = rd && !m_rdq;
      m_rdq = rd;
      case (ph)
        P_IDLE: if (cmd_valid) begin
          m_op = cmd_op;
          m_addr = addr_sw;
          m_data = data_sw;
          mq.delete();
          if (cmd_op == 2'd0) begin
            mq.push_back(8'hC3);
            for (int b = 0; b < 2; b++) mq.push_back(addr_sw[8*b +: 8]);
            ph = P_JAM;
          end else if (cmd_op == 2'd2) begin
            m_wa = m_panel;
            m_wd = data_sw;
            ph = P_DEP;
          end else begin
            mq.push_back(8'h00);
            ph = P_JAM;
          end
        end
        P_JAM: if (m_rise) begin
          if (mq.size() > 1) mq.delete(0);
          else ph = P_REL;
        end
        P_REL: if (!rd) begin
          mq.delete();
          if (m_op == 2'd0) m_panel = m_addr;
          else m_panel = m_panel + 16'd1;
          if (m_op == 2'd3) begin
            m_wa = m_panel;
            m_wd = m_data;
            ph = P_DEP;
          end else begin
            ph = P_FIN;
          end
        end
        P_DEP: ph = P_FIN;
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, on the falling edge.
  task automatic compare_loop();
    logic        e_jam;
    logic [7:0]  e_dout;
    forever begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (m_valid) begin
        e_jam  = (ph == P_JAM) || (ph == P_REL);
        e_dout = e_jam ? mq[0] : 8'h00;
        check("cmd_ready", 32'(cmd_ready), 32'(ph == P_IDLE));
        check("busy", 32'(busy), 32'(ph != P_IDLE));
        check("jam_en", 32'(jam_en), 32'(e_jam));
        check("data_out", 32'(data_out), 32'(e_dout));
        check("mem_wr", 32'(mem_wr), 32'(ph == P_DEP));
        check("done", 32'(done), 32'(ph == P_FIN));
        check("panel_addr", 32'(panel_addr), 32'(m_panel));
        check("mem_waddr", 32'(mem_waddr), 32'(m_wa));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wd));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    addr_sw   = a;
    data_sw   = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
  endtask

  task automatic examine(input logic [15:0] a);
    issue(2'd0, a, 8'h00);
    repeat (3) pulse();
    repeat (2) tick();
  endtask

  int saved_done;
  int hit;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    addr_sw = '0;
    data_sw = '0;
    rd = 1'b0;
    fork
      compare_loop();
    join_none
    repeat (2) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_jam_en", 32'(jam_en), 32'd0);
    check("rst_panel", 32'(panel_addr), 32'd0);
    reset = 1'b0;
    tick();

    // EXAMINE 1234: C3, 34, 12 then release
    saved_done = n_done;
    issue(2'd0, 16'h1234, 8'h00);
    check("ex_byte0", 32'(data_out), 32'h0C3);
    check("ex_jam_on", 32'(jam_en), 32'd1);
    pulse();
    check("ex_byte1", 32'(data_out), 32'h034);
    pulse();
    check("ex_byte2", 32'(data_out), 32'h012);
    pulse();
    check("ex_done", 32'(done), 32'd1);
    check("ex_jam_off", 32'(jam_en), 32'd0);
    check("ex_panel", 32'(panel_addr), 32'h1234);
    tick();
    check("ex_ready", 32'(cmd_ready), 32'd1);
    pulse();
    check("ex_4th_rd_panel", 32'(panel_addr), 32'h1234);
    check("ex_done_count", 32'(n_done - saved_done), 32'd1);

    // EXAMINE_NEXT wraps FFFF -> 0000
    examine(16'hFFFF);
    check("wrap_pre", 32'(panel_addr), 32'hFFFF);
    issue(2'd1, 16'h0000, 8'h00);
    check("exn_nop", 32'(data_out), 32'h000);
    check("exn_jam_on", 32'(jam_en), 32'd1);
    pulse();
    check("exn_wrap", 32'(panel_addr), 32'h0000);
    check("exn_done", 32'(done), 32'd1);
    tick();

    // DEPOSIT A5 at 0010
    examine(16'h0010);
    issue(2'd2, 16'hBEEF, 8'hA5);
    check("dep_wr", 32'(mem_wr), 32'd1);
    check("dep_waddr", 32'(mem_waddr), 32'h0010);
    check("dep_wdata", 32'(mem_wdata), 32'h0A5);
    check("dep_no_jam", 32'(jam_en), 32'd0);
    tick();
    check("dep_wr_once", 32'(mem_wr), 32'd0);
    check("dep_done", 32'(done), 32'd1);
    check("dep_hold", 32'(mem_wdata), 32'h0A5);
    tick();
    check("dep_ready", 32'(cmd_ready), 32'd1);

    // DEPOSIT_NEXT 3C from 0010 -> write at 0011
    issue(2'd3, 16'h0000, 8'h3C);
    check("dpn_nop", 32'(data_out), 32'h000);
    check("dpn_jam", 32'(jam_en), 32'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_wr === 1'b1) begin
        hit = 1;
        break;
      end
    end
    check("dpn_wr_seen", 32'(hit), 32'd1);
    check("dpn_waddr", 32'(mem_waddr), 32'h0011);
    check("dpn_wdata", 32'(mem_wdata), 32'h03C);
    check("dpn_panel", 32'(panel_addr), 32'h0011);
    tick();
    check("dpn_done", 32'(done), 32'd1);
    tick();

    // rd high at acceptance, second command while busy
    rd = 1'b1;
    tick();
    issue(2'd0, 16'h5678, 8'h00);
    cmd_valid = 1'b1;
    cmd_op = 2'd2;
    addr_sw = 16'h9999;
    data_sw = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_byte", 32'(data_out), 32'h0C3);
      check("busy_not_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    rd = 1'b0;
    tick();
    check("hold_still_op", 32'(data_out), 32'h0C3);
    pulse();
    check("fresh_rise_lo", 32'(data_out), 32'h078);
    pulse();
    check("fresh_rise_hi", 32'(data_out), 32'h056);
    pulse();
    tick();
    check("ignored_cmd_panel", 32'(panel_addr), 32'h5678);
    check("ignored_cmd_nowr", 32'(mem_wr), 32'd0);
    tick();

    // Reset while jamming address bytes
    issue(2'd0, 16'hABCD, 8'h00);
    pulse();
    check("pre_rst_byte", 32'(data_out), 32'h0CD);
    saved_done = n_done;
    reset = 1'b1;
    tick();
    check("rst_mid_jam", 32'(jam_en), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_panel", 32'(panel_addr), 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    check("rst_mid_no_done", 32'(n_done - saved_done), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom);
      addr_sw   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      data_sw   = 8'($urandom);
      rd        = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    cmd_valid = 1'b0;
    rd = 1'b0;
    reset = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
